// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan sequencer and its environment: scan control, mux select/data
// and the tagged sample output register.
interface mux_scan_ctrl_if #(
    parameter int NUM_CH = 31,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 5
);
    logic              start;
    logic              stop;
    logic              cont;
    logic [NUM_CH-1:0] chan_mask;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] mux_out;
    logic [DATA_W-1:0] data_out;
    logic [SEL_W-1:0]  data_chan;
    logic              data_valid;
    logic              data_ready;
    logic              busy;
    logic              done;

    // A sample transfers on a rising edge where data_valid && data_ready; data_valid never
    // drops and data_out/data_chan never change while a sample waits for data_ready.
    modport master (
        input  start, stop, cont, chan_mask, mux_out, data_ready,
        output sel, data_out, data_chan, data_valid, busy, done
    );

    modport slave (
        output start, stop, cont, chan_mask, mux_out, data_ready,
        input  sel, data_out, data_chan, data_valid, busy, done
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the channel mux: steps sel through the enabled channels and captures
// each mux sample, tagged with its channel, into a one-entry valid/ready output register.
module mux_scan_ctrl #(
    parameter int NUM_CH = 31,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_scan_ctrl_if.master  scan_if,
    output logic [1:0]       state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              cont_q, cont_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  chan_q, chan_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic              free_slot;
    logic              capture;
    logic [SEL_W-1:0]  start_idx;
    logic [SEL_W-1:0]  wrap_idx;
    logic [SEL_W-1:0]  next_idx;
    logic              next_found;

    assign free_slot = !valid_q || scan_if.data_ready;

    // Downward scans with last-hit-wins yield the lowest qualifying index.
    always_comb begin
        start_idx  = '0;
        wrap_idx   = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (scan_if.chan_mask[i]) begin
                start_idx = SEL_W'(i);
            end
            if (mask_q[i]) begin
                wrap_idx = SEL_W'(i);
            end
            if (mask_q[i] && (i > int'(sel_q))) begin
                next_idx   = SEL_W'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_if.start) begin
                    if (|scan_if.chan_mask) begin
                        state_d = ST_SCAN;
                        mask_d  = scan_if.chan_mask;
                        cont_d  = scan_if.cont;
                        sel_d   = start_idx;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                // stop wins over a capture in the same cycle.
                if (scan_if.stop) begin
                    state_d = ST_DRAIN;
                end else if (free_slot) begin
                    capture = 1'b1;
                    if (next_found) begin
                        sel_d = next_idx;
                    end else if (cont_q) begin
                        sel_d = wrap_idx;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!valid_q || scan_if.data_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (capture) begin
            data_d  = scan_if.mux_out;
            chan_d  = sel_q;
            valid_d = 1'b1;
        end else if (valid_q && scan_if.data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            cont_q  <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign scan_if.sel        = sel_q;
    assign scan_if.data_out   = data_q;
    assign scan_if.data_chan  = chan_q;
    assign scan_if.data_valid = valid_q;
    assign scan_if.busy       = (state_q != ST_IDLE);
    assign scan_if.done       = done_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: modelled mux (base + sel), scoreboard of expected
// {channel, data} beats popped on every accepted output transfer.
module tb_mux_scan_ctrl;

    localparam int NUM_CH = 31;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 5;
    localparam int ENT_W  = SEL_W + DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_scan_ctrl_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) scan_if ();
    logic [1:0]        state_o;
    logic [DATA_W-1:0] mux_base;

    assign scan_if.mux_out = mux_base + DATA_W'(scan_if.sel);

    mux_scan_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scan_if (scan_if),
        .state_o (state_o)
    );

    int total = 0;
    int bad = 0;
    logic [ENT_W-1:0] exp_q[$];
    int cyc = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    int last_beat_cyc = 0;
    int last_done_cyc = 0;
    bit sel1_seen = 0;

    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [SEL_W-1:0]  prev_chan;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard pops, hold-stability and select-range checks.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [ENT_W-1:0] got;
            logic [ENT_W-1:0] want;
            if (scan_if.done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (scan_if.busy && scan_if.sel == SEL_W'(1)) sel1_seen = 1;
            total++;
            if (int'(scan_if.sel) >= NUM_CH) begin
                bad++;
                $display("FAIL sel_range: sel=%0d limit=%0d", scan_if.sel, NUM_CH - 1);
            end
            if (prev_stall && scan_if.data_valid) begin
                total++;
                if ({scan_if.data_chan, scan_if.data_out} !== {prev_chan, prev_data}) begin
                    bad++;
                    $display("FAIL hold_stable: got chan=%0d data=%h want chan=%0d data=%h",
                             scan_if.data_chan, scan_if.data_out, prev_chan, prev_data);
                end
            end
            if (scan_if.data_valid && scan_if.data_ready) begin
                got = {scan_if.data_chan, scan_if.data_out};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: got chan=%0d data=%h want none",
                             scan_if.data_chan, scan_if.data_out);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL beat: got chan=%0d data=%h want chan=%0d data=%h",
                                 got[ENT_W-1:DATA_W], got[DATA_W-1:0],
                                 want[ENT_W-1:DATA_W], want[DATA_W-1:0]);
                    end
                end
                beat_cnt++;
                last_beat_cyc = cyc;
            end
            prev_stall = scan_if.data_valid && !scan_if.data_ready;
            prev_data  = scan_if.data_out;
            prev_chan  = scan_if.data_chan;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_scan(input logic [NUM_CH-1:0] m, input logic [DATA_W-1:0] b);
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) exp_q.push_back({SEL_W'(i), b + DATA_W'(i)});
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt != d0);
    endtask

    task automatic launch(input logic [NUM_CH-1:0] m, input logic c);
        scan_if.chan_mask = m;
        scan_if.cont = c;
        scan_if.start = 1'b1;
        tick();
        scan_if.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        total++;
        if ({scan_if.sel, scan_if.data_out, scan_if.data_chan, scan_if.data_valid,
             scan_if.busy, scan_if.done} !== '0) begin
            bad++;
            $display("FAIL reset_state: sel=%0d data=%h chan=%0d valid=%b busy=%b done=%b want all 0",
                     scan_if.sel, scan_if.data_out, scan_if.data_chan, scan_if.data_valid,
                     scan_if.busy, scan_if.done);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_pass();
        bit ok;
        int b0;
        mux_base = 8'hA0;
        scan_if.data_ready = 1'b1;
        sel1_seen = 0;
        b0 = beat_cnt;
        push_scan(31'h0000_0005, 8'hA0);
        launch(31'h0000_0005, 1'b0);
        scan_if.chan_mask = '1;
        wait_done(50, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL single_done: got timeout want done"); end
        total++;
        if (beat_cnt - b0 !== 2) begin bad++; $display("FAIL single_beats: got %0d want 2", beat_cnt - b0); end
        total++;
        if (sel1_seen !== 1'b0) begin bad++; $display("FAIL single_sel1: got sel=1 seen want never"); end
        total++;
        if (last_done_cyc - last_beat_cyc !== 1) begin
            bad++;
            $display("FAIL single_done_lat: got %0d want 1", last_done_cyc - last_beat_cyc);
        end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL single_left: got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_wrap_stop();
        bit ok;
        int b0;
        mux_base = 8'h40;
        scan_if.data_ready = 1'b1;
        b0 = beat_cnt;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({SEL_W'(0), 8'h40});
            exp_q.push_back({SEL_W'(30), 8'h5E});
        end
        launch(31'h4000_0001, 1'b1);
        scan_if.cont = 1'b0;
        repeat (6) tick();
        scan_if.stop = 1'b1;
        tick();
        scan_if.stop = 1'b0;
        wait_done(20, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL wrap_done: got timeout want done"); end
        total++;
        if (beat_cnt - b0 !== 6) begin bad++; $display("FAIL wrap_beats: got %0d want 6", beat_cnt - b0); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL wrap_left: got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit ok;
        int b0;
        mux_base = 8'h10;
        scan_if.data_ready = 1'b1;
        b0 = beat_cnt;
        push_scan('1, 8'h10);
        launch('1, 1'b0);
        tick();
        scan_if.data_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({scan_if.sel, scan_if.data_chan, scan_if.data_out, scan_if.data_valid} !==
                {SEL_W'(1), SEL_W'(0), 8'h10, 1'b1}) begin
                bad++;
                $display("FAIL bp_frozen: got sel=%0d chan=%0d data=%h valid=%b want sel=1 chan=0 data=10 valid=1",
                         scan_if.sel, scan_if.data_chan, scan_if.data_out, scan_if.data_valid);
            end
        end
        @(posedge clk);
        #1;
        scan_if.data_ready = 1'b1;
        wait_done(100, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL bp_done: got timeout want done"); end
        total++;
        if (beat_cnt - b0 !== 31) begin bad++; $display("FAIL bp_beats: got %0d want 31", beat_cnt - b0); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL bp_left: got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_empty_mask();
        int b0;
        b0 = beat_cnt;
        launch('0, 1'b0);
        @(negedge clk);
        total++;
        if ({scan_if.done, scan_if.busy, scan_if.data_valid} !== 3'b100) begin
            bad++;
            $display("FAIL empty_pulse: got done=%b busy=%b valid=%b want 1 0 0",
                     scan_if.done, scan_if.busy, scan_if.data_valid);
        end
        @(negedge clk);
        total++;
        if ({scan_if.done, scan_if.busy, scan_if.data_valid} !== 3'b000) begin
            bad++;
            $display("FAIL empty_after: got done=%b busy=%b valid=%b want 0 0 0",
                     scan_if.done, scan_if.busy, scan_if.data_valid);
        end
        total++;
        if (beat_cnt !== b0) begin bad++; $display("FAIL empty_beats: got %0d want 0", beat_cnt - b0); end
    endtask

    task automatic test_stop_free();
        bit ok;
        mux_base = 8'h60;
        scan_if.data_ready = 1'b1;
        push_scan(31'h0000_0010, 8'h60);
        launch(31'h0000_00F0, 1'b0);
        tick();
        scan_if.stop = 1'b1;
        tick();
        scan_if.stop = 1'b0;
        wait_done(20, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL stopfree_done: got timeout want done"); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL stopfree_left: got %0d want 0", exp_q.size()); end
        exp_q.delete();
        // Stop while the consumer stalls: the held beat must drain before done.
        push_scan(31'h0000_0010, 8'h60);
        tick();
        launch(31'h0000_00F0, 1'b0);
        tick();
        scan_if.stop = 1'b1;
        scan_if.data_ready = 1'b0;
        tick();
        scan_if.stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if ({scan_if.busy, scan_if.data_valid, scan_if.done, scan_if.data_chan} !==
                {1'b1, 1'b1, 1'b0, SEL_W'(4)}) begin
                bad++;
                $display("FAIL drain_hold: got busy=%b valid=%b done=%b chan=%0d want 1 1 0 4",
                         scan_if.busy, scan_if.data_valid, scan_if.done, scan_if.data_chan);
            end
        end
        @(posedge clk);
        #1;
        scan_if.data_ready = 1'b1;
        wait_done(20, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL drain_done: got timeout want done"); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL drain_left: got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_scan();
        mux_base = 8'h20;
        scan_if.data_ready = 1'b0;
        launch('1, 1'b0);
        repeat (2) tick();
        @(negedge clk);
        total++;
        if (scan_if.data_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre: got valid=%b want 1", scan_if.data_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({scan_if.sel, scan_if.data_out, scan_if.data_chan, scan_if.data_valid,
             scan_if.busy, scan_if.done} !== '0) begin
            bad++;
            $display("FAIL midrst_state: sel=%0d data=%h chan=%0d valid=%b busy=%b done=%b want all 0",
                     scan_if.sel, scan_if.data_out, scan_if.data_chan, scan_if.data_valid,
                     scan_if.busy, scan_if.done);
        end
        rst_n = 1'b1;
        scan_if.data_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({scan_if.done, scan_if.data_valid, scan_if.busy} !== 3'b000) begin
                bad++;
                $display("FAIL midrst_after: got done=%b valid=%b busy=%b want 0 0 0",
                         scan_if.done, scan_if.data_valid, scan_if.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NUM_CH-1:0] m;
        logic [DATA_W-1:0] b;
        int d0;
        int n;
        tick();
        for (int r = 0; r < 4; r++) begin
            m = NUM_CH'($urandom());
            if (m == '0) m[3] = 1'b1;
            b = DATA_W'($urandom_range(0, 255));
            mux_base = b;
            scan_if.data_ready = 1'b1;
            push_scan(m, b);
            d0 = done_cnt;
            launch(m, 1'b0);
            n = 0;
            while (done_cnt == d0 && n < 400) begin
                @(posedge clk);
                #1;
                scan_if.data_ready = 1'($urandom_range(0, 1));
                n++;
            end
            scan_if.data_ready = 1'b1;
            total++;
            if (done_cnt == d0) begin bad++; $display("FAIL b2b_done: round=%0d got timeout want done", r); end
            total++;
            if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_left: round=%0d got %0d want 0", r, exp_q.size()); end
            exp_q.delete();
        end
    endtask

    initial begin
        scan_if.start = 1'b0;
        scan_if.stop = 1'b0;
        scan_if.cont = 1'b0;
        scan_if.chan_mask = '0;
        scan_if.data_ready = 1'b1;
        mux_base = 8'h00;
        test_reset();
        test_single_pass();
        test_wrap_stop();
        test_backpressure();
        test_empty_mask();
        test_stop_free();
        test_reset_mid_scan();
        test_back_to_back();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
